aes_mode_engine: RTL and testbench



---
 rtl/aes_mode_engine.sv | 207 ++++++++++++++++++++
 tb/tb_aes_mode_engine.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mode_engine.sv
// Block-mode sequencer (ECB/CBC/CTR) in front of a single-block AES core wrapper.
// Latches a configuration, runs the decryption key-schedule pass when needed, then streams one block at a time.
`timescale 1ns/1ps
module aes_mode_engine #(
  parameter int KEY_W = 256,
  parameter int CTR_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [1:0]         mode_i,
  input  logic               dec_i,
  input  logic [KEY_W-1:0]   key_i,
  input  logic [127:0]       iv_i,
  input  logic               clear_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [127:0]       in_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [127:0]       out_data_o,
  output logic               err_o,
  output logic               core_in_valid_o,
  input  logic               core_in_ready_i,
  input  logic               core_out_valid_i,
  output logic               core_out_ready_o,
  output logic [1:0]         core_op_o,
  output logic [2:0]         core_key_len_o,
  output logic               core_crypt_o,
  output logic               core_dec_key_gen_o,
  output logic [255:0]       core_key_o,
  output logic [127:0]       core_state_o,
  input  logic [127:0]       core_state_i
);

  // Handshakes: a transfer happens on a rising clk_i edge where valid and ready are both high;
  // a valid, once raised, is held with stable payload until that transfer.

  typedef enum logic [2:0] {
    S_IDLE,
    S_DKEY_REQ,
    S_DKEY_WAIT,
    S_READY,
    S_REQ,
    S_WAIT,
    S_OUT
  } state_e;

  localparam logic [1:0] MODE_ECB = 2'd0;
  localparam logic [1:0] MODE_CBC = 2'd1;
  localparam logic [1:0] MODE_CTR = 2'd2;
  localparam logic [1:0] MODE_BAD = 2'd3;

  localparam logic [1:0] OP_FWD = 2'b01;
  localparam logic [1:0] OP_INV = 2'b10;

  localparam logic [2:0] KEY_LEN = (KEY_W == 128) ? 3'b001 :
                                   (KEY_W == 192) ? 3'b010 : 3'b100;

  // For CTR_W = 128 the shift yields zero and the subtraction wraps to all-ones.
  localparam logic [127:0] CTR_MASK = (128'd1 << CTR_W) - 128'd1;

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic               dec_q, dec_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [127:0]       chain_q, chain_d;
  logic [127:0]       data_q, data_d;
  logic [127:0]       result_q, result_d;
  logic               err_q, err_d;

  logic               use_inv;
  logic [127:0]       ctr_next;
  logic [255:0]       key_ext;

  assign use_inv  = dec_q && (mode_q != MODE_CTR);
  assign ctr_next = (chain_q & ~CTR_MASK) | ((chain_q + 128'd1) & CTR_MASK);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    dec_d    = dec_q;
    key_d    = key_q;
    chain_d  = chain_q;
    data_d   = data_q;
    result_d = result_q;
    err_d    = err_q;
    if (clear_i) begin
      state_d  = S_IDLE;
      mode_d   = MODE_ECB;
      dec_d    = 1'b0;
      key_d    = '0;
      chain_d  = '0;
      data_d   = '0;
      result_d = '0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_valid_i) begin
            if (mode_i == MODE_BAD) begin
              err_d = 1'b1;
            end else begin
              err_d   = 1'b0;
              mode_d  = mode_i;
              dec_d   = dec_i;
              key_d   = key_i;
              chain_d = iv_i;
              state_d = (dec_i && (mode_i != MODE_CTR)) ? S_DKEY_REQ : S_READY;
            end
          end
        end
        S_DKEY_REQ: if (core_in_ready_i) state_d = S_DKEY_WAIT;
        S_DKEY_WAIT: if (core_out_valid_i) state_d = S_READY;
        S_READY: begin
          if (in_valid_i) begin
            data_d  = in_data_i;
            state_d = S_REQ;
          end
        end
        S_REQ: if (core_in_ready_i) state_d = S_WAIT;
        S_WAIT: begin
          if (core_out_valid_i) begin
            state_d = S_OUT;
            case (mode_q)
              MODE_CBC: begin
                if (dec_q) begin
                  result_d = core_state_i ^ chain_q;
                  chain_d  = data_q;
                end else begin
                  result_d = core_state_i;
                  chain_d  = core_state_i;
                end
              end
              MODE_CTR: begin
                result_d = core_state_i ^ data_q;
                chain_d  = ctr_next;
              end
              default: result_d = core_state_i;
            endcase
          end
        end
        S_OUT: if (out_ready_i) state_d = S_READY;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE_ECB;
      dec_q    <= 1'b0;
      key_q    <= '0;
      chain_q  <= '0;
      data_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      dec_q    <= dec_d;
      key_q    <= key_d;
      chain_q  <= chain_d;
      data_q   <= data_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    key_ext              = '0;
    key_ext[KEY_W-1:0]   = key_q;
  end

  assign cfg_ready_o        = (state_q == S_IDLE);
  assign in_ready_o         = (state_q == S_READY);
  assign out_valid_o        = (state_q == S_OUT);
  assign out_data_o         = result_q;
  assign err_o              = err_q;
  assign core_in_valid_o    = (state_q == S_REQ) || (state_q == S_DKEY_REQ);
  assign core_out_ready_o   = (state_q == S_WAIT) || (state_q == S_DKEY_WAIT);
  assign core_crypt_o       = (state_q == S_REQ) || (state_q == S_WAIT);
  assign core_dec_key_gen_o = (state_q == S_DKEY_REQ) || (state_q == S_DKEY_WAIT);
  assign core_key_len_o     = KEY_LEN;
  assign core_key_o         = key_ext;

  // Key-generation pass always feeds an all-zero block; data passes pick their input per mode.
  always_comb begin
    core_op_o    = 2'b00;
    core_state_o = '0;
    case (state_q)
      S_DKEY_REQ, S_DKEY_WAIT: core_op_o = OP_INV;
      S_REQ, S_WAIT:           core_op_o = use_inv ? OP_INV : OP_FWD;
      default:                 core_op_o = 2'b00;
    endcase
    if (state_q == S_REQ) begin
      case (mode_q)
        MODE_CBC: core_state_o = dec_q ? data_q : (data_q ^ chain_q);
        MODE_CTR: core_state_o = chain_q;
        default:  core_state_o = data_q;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_mode_engine.sv
// Self-checking bench for aes_mode_engine with a keyed-permutation stand-in for the cipher core.
// Expected blocks come from a mode-level reference model applied to whole message arrays.
`timescale 1ns/1ps
module tb_aes_mode_engine;

  logic          clk = 1'b0;
  logic          rst_i, cfg_valid_i, dec_i, clear_i, in_valid_i, out_ready_i;
  logic [1:0]    mode_i;
  logic [255:0]  key_i;
  logic [127:0]  iv_i, in_data_i;
  logic          cfg_ready_o, in_ready_o, out_valid_o, err_o;
  logic [127:0]  out_data_o;
  logic          core_in_valid_o, core_in_ready_i, core_out_valid_i, core_out_ready_o;
  logic [1:0]    core_op_o;
  logic [2:0]    core_key_len_o;
  logic          core_crypt_o, core_dec_key_gen_o;
  logic [255:0]  core_key_o;
  logic [127:0]  core_state_o, core_state_i;

  always #5 clk = ~clk;

  aes_mode_engine #(.KEY_W(256), .CTR_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .mode_i(mode_i), .dec_i(dec_i), .key_i(key_i), .iv_i(iv_i), .clear_i(clear_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .err_o(err_o),
    .core_in_valid_o(core_in_valid_o), .core_in_ready_i(core_in_ready_i),
    .core_out_valid_i(core_out_valid_i), .core_out_ready_o(core_out_ready_o),
    .core_op_o(core_op_o), .core_key_len_o(core_key_len_o),
    .core_crypt_o(core_crypt_o), .core_dec_key_gen_o(core_dec_key_gen_o),
    .core_key_o(core_key_o), .core_state_o(core_state_o), .core_state_i(core_state_i)
  );

  int errors = 0;
  int checks = 0;

  logic [127:0] exp_q[$];
  logic [127:0] req_hist[$];
  logic [127:0] blk_in[8];
  logic [127:0] blk_out[8];
  logic [127:0] pt_save[8];

  int           dkg_cnt = 0;
  logic [1:0]   last_op = 2'b00;
  logic         lat_flag = 1'b0;
  logic         core_flush = 1'b0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stand-in cipher: rotate-and-add keyed permutation with an exact inverse.
  function automatic logic [127:0] fwd(input logic [127:0] x, input logic [255:0] key);
    logic [127:0] k, t;
    k = key[127:0] ^ key[255:128];
    t = x ^ k;
    return {t[114:0], t[127:115]} + k;
  endfunction

  function automatic logic [127:0] inv(input logic [127:0] y, input logic [255:0] key);
    logic [127:0] k, t;
    k = key[127:0] ^ key[255:128];
    t = y - k;
    return {t[12:0], t[127:13]} ^ k;
  endfunction

  // Core model: random accept delay, random 1..4 cycle latency, one operation at a time.
  initial begin
    int cphase, clat;
    logic [127:0] creq_state;
    logic [1:0]   creq_op;
    logic         creq_crypt, creq_dkg;
    logic [255:0] creq_key;
    core_in_ready_i = 1'b0; core_out_valid_i = 1'b0; core_state_i = '0;
    cphase = 0; clat = 0;
    creq_state = '0; creq_op = 2'b00; creq_crypt = 1'b0; creq_dkg = 1'b0; creq_key = '0;
    forever begin
      @(negedge clk);
      if (rst_i || core_flush) begin
        core_in_ready_i = 1'b0; core_out_valid_i = 1'b0; cphase = 0;
      end else begin
        case (cphase)
          0: if (core_in_valid_o && ($urandom_range(0, 2) != 0)) begin
            core_in_ready_i = 1'b1;
            creq_state = core_state_o; creq_op = core_op_o;
            creq_crypt = core_crypt_o; creq_dkg = core_dec_key_gen_o; creq_key = core_key_o;
            cphase = 1;
          end
          1: begin
            core_in_ready_i = 1'b0;
            if (creq_dkg) dkg_cnt++;
            if (creq_crypt) begin
              req_hist.push_back(creq_state);
              last_op = creq_op;
            end
            clat = $urandom_range(0, 3);
            cphase = 2;
          end
          2: if (clat == 0) begin
            core_out_valid_i = 1'b1;
            if (creq_dkg) core_state_i = rnd128();
            else if (creq_op == 2'b10) core_state_i = inv(creq_state, creq_key);
            else core_state_i = fwd(creq_state, creq_key);
            cphase = 3;
          end else clat--;
          default: begin
            core_out_valid_i = 1'b0;
            if (creq_crypt) lat_flag = out_valid_o;
            cphase = 0;
          end
        endcase
      end
    end
  end

  // Reference model: whole-message mode arithmetic.
  task automatic model(input logic [1:0] mode, input logic dec, input logic [255:0] key,
                       input logic [127:0] iv, input int n);
    logic [127:0] chain, d, e;
    chain = iv;
    for (int i = 0; i < n; i++) begin
      d = blk_in[i];
      if (mode == 2'd0) begin
        e = dec ? inv(d, key) : fwd(d, key);
      end else if (mode == 2'd1) begin
        if (dec) begin e = inv(d, key) ^ chain; chain = d; end
        else begin e = fwd(d ^ chain, key); chain = e; end
      end else begin
        e = fwd(chain, key) ^ d;
        chain[31:0] = chain[31:0] + 32'd1;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic do_cfg(input logic [1:0] mode, input logic dec, input logic [255:0] key,
                        input logic [127:0] iv);
    chk("cfg_ready_before_cfg", cfg_ready_o, 1'b1);
    mode_i = mode; dec_i = dec; key_i = key; iv_i = iv; cfg_valid_i = 1'b1;
    @(negedge clk);
    cfg_valid_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    chk("clear_to_idle", cfg_ready_o, 1'b1);
    chk("clear_err", err_o, 1'b0);
  endtask

  task automatic send_block(input logic [127:0] d);
    int t = 0;
    while (!in_ready_o && t < 200) begin @(negedge clk); t++; end
    chk("in_ready_timeout", in_ready_o, 1'b1);
    if (in_ready_o) begin
      in_valid_i = 1'b1; in_data_i = d;
      @(negedge clk);
      in_valid_i = 1'b0;
      chk("req_latency", core_in_valid_o, 1'b1);
    end
  endtask

  task automatic recv_block(input string tag, input int bp, input int idx);
    int t = 0;
    logic [127:0] held;
    while (!out_valid_o && t < 200) begin @(negedge clk); t++; end
    chk({tag, "_out_timeout"}, out_valid_o, 1'b1);
    if (!out_valid_o) return;
    held = out_data_o;
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      chk("bp_valid_held", out_valid_o, 1'b1);
      chk("bp_data_stable", out_data_o, held);
      chk("bp_in_ready_low", in_ready_o, 1'b0);
    end
    out_ready_i = 1'b1;
    blk_out[idx] = out_data_o;
    if (exp_q.size() > 0) chk({tag, "_data"}, out_data_o, exp_q.pop_front());
    else chk({tag, "_unexpected_out"}, 1'b1, 1'b0);
    @(negedge clk);
    out_ready_i = 1'b0;
    chk({tag, "_in_ready_after_out"}, in_ready_o, 1'b1);
  endtask

  task automatic stream(input string tag, input logic [1:0] mode, input logic dec,
                        input logic [255:0] key, input logic [127:0] iv, input int n,
                        input int bp_blk);
    int dk0;
    logic [1:0] op_exp;
    op_exp = (dec && mode != 2'd2) ? 2'b10 : 2'b01;
    exp_q.delete(); req_hist.delete();
    model(mode, dec, key, iv, n);
    dk0 = dkg_cnt;
    do_cfg(mode, dec, key, iv);
    for (int i = 0; i < n; i++) begin
      lat_flag = 1'b0;
      send_block(blk_in[i]);
      recv_block(tag, (i == bp_blk) ? 5 : $urandom_range(0, 2), i);
      chk({tag, "_core_op"}, last_op, op_exp);
      chk({tag, "_out_latency"}, lat_flag, 1'b1);
    end
    chk({tag, "_dkey_passes"}, dkg_cnt - dk0, (dec && mode != 2'd2) ? 1 : 0);
    do_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] key;
    logic [127:0] iv;
    int t;
    rst_i = 1'b1; cfg_valid_i = 1'b0; dec_i = 1'b0; clear_i = 1'b0; in_valid_i = 1'b0;
    out_ready_i = 1'b0; mode_i = 2'd0; key_i = '0; iv_i = '0; in_data_i = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;

    chk("rst_cfg_ready", cfg_ready_o, 1'b1);
    chk("rst_in_ready", in_ready_o, 1'b0);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_out_data", out_data_o, 128'd0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_core_in_valid", core_in_valid_o, 1'b0);
    chk("rst_core_out_ready", core_out_ready_o, 1'b0);
    chk("rst_core_op", core_op_o, 2'b00);
    chk("rst_core_strobes", {core_crypt_o, core_dec_key_gen_o}, 2'b00);
    chk("rst_core_key", core_key_o, 256'd0);
    chk("rst_core_state", core_state_o, 128'd0);
    chk("rst_key_len", core_key_len_o, 3'b100);

    key = {rnd128(), rnd128()};
    for (int i = 0; i < 4; i++) blk_in[i] = rnd128();
    stream("ecb_enc", 2'd0, 1'b0, key, rnd128(), 4, -1);
    for (int i = 0; i < 3; i++) blk_in[i] = rnd128();
    stream("ecb_dec", 2'd0, 1'b1, key, rnd128(), 3, -1);

    key = {rnd128(), rnd128()}; iv = rnd128();
    for (int i = 0; i < 3; i++) begin blk_in[i] = rnd128(); pt_save[i] = blk_in[i]; end
    stream("cbc_enc", 2'd1, 1'b0, key, iv, 3, 1);
    for (int i = 0; i < 3; i++) blk_in[i] = blk_out[i];
    stream("cbc_dec", 2'd1, 1'b1, key, iv, 3, -1);
    for (int i = 0; i < 3; i++) chk("cbc_roundtrip", blk_out[i], pt_save[i]);

    key = {rnd128(), rnd128()};
    iv = {rnd128() >> 32, 32'hffff_ffff};
    blk_in[0] = rnd128(); blk_in[1] = rnd128();
    stream("ctr_wrap", 2'd2, 1'b0, key, iv, 2, -1);
    if (req_hist.size() == 2) begin
      chk("ctr_first_counter", req_hist[0], iv);
      chk("ctr_wrap_low", req_hist[1][31:0], 32'd0);
      chk("ctr_wrap_upper", req_hist[1][127:32], iv[127:32]);
    end else chk("ctr_req_count", req_hist.size(), 2);
    for (int i = 0; i < 4; i++) blk_in[i] = rnd128();
    stream("ctr_dec", 2'd2, 1'b1, key, rnd128(), 4, 2);

    // Abort in WAIT.
    exp_q.delete();
    do_cfg(2'd0, 1'b0, key, rnd128());
    send_block(rnd128());
    t = 0;
    while (!core_out_ready_o && t < 100) begin @(negedge clk); t++; end
    chk("abort_reached_wait", core_out_ready_o, 1'b1);
    clear_i = 1'b1; core_flush = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    chk("abort_idle", cfg_ready_o, 1'b1);
    chk("abort_key_zero", core_key_o, 256'd0);
    for (int k = 0; k < 3; k++) begin
      chk("abort_no_out", out_valid_o, 1'b0);
      @(negedge clk);
    end
    core_flush = 1'b0;
    @(negedge clk);

    // Illegal mode.
    do_cfg(2'd3, 1'b0, key, rnd128());
    chk("illegal_err", err_o, 1'b1);
    chk("illegal_idle", cfg_ready_o, 1'b1);
    chk("illegal_in_ready", in_ready_o, 1'b0);
    @(negedge clk);
    chk("illegal_err_sticky", err_o, 1'b1);
    chk("illegal_still_idle", in_ready_o, 1'b0);
    do_clear();
    do_cfg(2'd3, 1'b1, key, rnd128());
    chk("illegal_err2", err_o, 1'b1);
    do_cfg(2'd0, 1'b0, key, rnd128());
    chk("legal_cfg_clears_err", err_o, 1'b0);
    chk("legal_cfg_ready_state", in_ready_o, 1'b1);
    do_clear();

    // Clear wins over a simultaneous cfg.
    mode_i = 2'd0; dec_i = 1'b0; key_i = {rnd128(), rnd128()} | 256'd1; iv_i = rnd128();
    cfg_valid_i = 1'b1; clear_i = 1'b1;
    @(negedge clk);
    cfg_valid_i = 1'b0; clear_i = 1'b0;
    chk("clear_cfg_idle", cfg_ready_o, 1'b1);
    chk("clear_cfg_no_key", core_key_o, 256'd0);
    chk("clear_cfg_in_ready", in_ready_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
